debug_bus_master: RTL and testbench

//  Byte-stream-to-debug-bus bridge; the initiator side of the debug bus that register

---
 rtl/debug_bus_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_debug_bus_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_bus_master.sv
//------------------------------------------------------------------------------
// debug_bus_master
//
// Initiator side of the debug bus. Parses command bytes arriving on an RX byte
// stream and turns them into debug bus accesses; response bytes go out on a TX
// byte stream.
//
//   0x01 A_HI A_LO D : write D to {A_HI,A_LO}, reply ACK_BYTE
//   0x02 A_HI A_LO N : read N bytes from consecutive addresses (N=0 -> 256),
//                      reply with each byte; TIMEOUT_BYTE on a silent
//                      responder, after which the rest of the burst is dropped
//   anything else    : swallowed, no reply
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   rx_data/valid/ready   command byte stream (consumed on valid && ready)
//   tx_data/valid/ready   response byte stream (held until valid && ready)
//   bus_addr, bus_write_data, bus_write_enable, bus_read_enable
//                     request side of the debug bus, held until bus_ready
//   bus_ready         responder accepts the pending request this cycle
//   bus_read_data/valid   read return path, honoured only while waiting
//
// Every output is driven straight from a flop.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module debug_bus_master #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  ACK_BYTE     = 8'h4B,
  parameter logic [7:0]  TIMEOUT_BYTE = 8'hEE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_write_data,
  output logic                  bus_write_enable,
  output logic                  bus_read_enable,
  input  logic                  bus_ready,
  input  logic [7:0]            bus_read_data,
  input  logic                  bus_read_valid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_HI  = 3'd1,
    S_ADDR_LO  = 3'd2,
    S_ARG      = 3'd3,
    S_BUS_REQ  = 3'd4,
    S_BUS_WAIT = 3'd5,
    S_TX       = 3'd6
  } state_t;

  // Last timer value still allowed to wait; the abort fires on that cycle
  // unless read data shows up in it.
  localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_next;
  logic                  is_write, is_write_next;
  logic                  aborted, aborted_next;
  logic [7:0]            addr_hi, addr_hi_next;
  logic [8:0]            count, count_next;
  logic [15:0]           timer, timer_next;
  logic [15:0]           addr_full;
  logic                  rx_accept;
  logic                  rx_ready_next;
  logic [7:0]            tx_data_next;
  logic                  tx_valid_next;
  logic [ADDR_WIDTH-1:0] bus_addr_next;
  logic [7:0]            bus_write_data_next;
  logic                  bus_write_enable_next;
  logic                  bus_read_enable_next;

  // rx_ready is only ever high in the parsing states.
  function automatic logic is_parse_state(input state_t s);
    case (s)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_ARG: is_parse_state = 1'b1;
      default:                             is_parse_state = 1'b0;
    endcase
  endfunction

  assign rx_accept = rx_valid && rx_ready;
  // Upper received address bits beyond ADDR_WIDTH are simply dropped.
  assign addr_full = {addr_hi, rx_data};

  // Next-state and next-output decode.
  always_comb begin
    state_next            = state;
    is_write_next         = is_write;
    aborted_next          = aborted;
    addr_hi_next          = addr_hi;
    count_next            = count;
    timer_next            = timer;
    tx_data_next          = tx_data;
    tx_valid_next         = tx_valid;
    bus_addr_next         = bus_addr;
    bus_write_data_next   = bus_write_data;
    bus_write_enable_next = bus_write_enable;
    bus_read_enable_next  = bus_read_enable;

    case (state)
      S_IDLE: begin
        if (rx_accept) begin
          if (rx_data == 8'h01) begin
            is_write_next = 1'b1;
            state_next    = S_ADDR_HI;
          end else if (rx_data == 8'h02) begin
            is_write_next = 1'b0;
            state_next    = S_ADDR_HI;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          state_next = S_IDLE;
        end
      end

      S_ADDR_HI: begin
        if (rx_accept) begin
          addr_hi_next = rx_data;
          state_next   = S_ADDR_LO;
        end else begin
          state_next = S_ADDR_HI;
        end
      end

      S_ADDR_LO: begin
        if (rx_accept) begin
          bus_addr_next = addr_full[ADDR_WIDTH-1:0];
          state_next    = S_ARG;
        end else begin
          state_next = S_ADDR_LO;
        end
      end

      S_ARG: begin
        if (rx_accept) begin
          aborted_next = 1'b0;
          state_next   = S_BUS_REQ;
          if (is_write) begin
            bus_write_data_next   = rx_data;
            bus_write_enable_next = 1'b1;
            count_next            = 9'd1;
          end else begin
            bus_read_enable_next = 1'b1;
            count_next           = (rx_data == 8'h00) ? 9'h100 : {1'b0, rx_data};
          end
        end else begin
          state_next = S_ARG;
        end
      end

      S_BUS_REQ: begin
        // Request stays on the bus untouched until the responder takes it.
        if (bus_ready) begin
          bus_write_enable_next = 1'b0;
          bus_read_enable_next  = 1'b0;
          if (is_write) begin
            tx_data_next  = ACK_BYTE;
            tx_valid_next = 1'b1;
            state_next    = S_TX;
          end else begin
            timer_next = 16'd0;
            state_next = S_BUS_WAIT;
          end
        end else begin
          state_next = S_BUS_REQ;
        end
      end

      S_BUS_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the abort.
        if (bus_read_valid) begin
          tx_data_next  = bus_read_data;
          tx_valid_next = 1'b1;
          state_next    = S_TX;
        end else if (timer >= TIMEOUT_LAST) begin
          tx_data_next  = TIMEOUT_BYTE;
          tx_valid_next = 1'b1;
          aborted_next  = 1'b1;
          state_next    = S_TX;
        end else begin
          timer_next = timer + 16'd1;
        end
      end

      S_TX: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (!is_write && !aborted && (count > 9'd1)) begin
            count_next           = count - 9'd1;
            bus_addr_next        = bus_addr + ADDR_ONE;
            bus_read_enable_next = 1'b1;
            state_next           = S_BUS_REQ;
          end else begin
            count_next = 9'd0;
            state_next = S_IDLE;
          end
        end else begin
          state_next = S_TX;
        end
      end

      default: begin
        state_next            = S_IDLE;
        tx_valid_next         = 1'b0;
        bus_write_enable_next = 1'b0;
        bus_read_enable_next  = 1'b0;
      end
    endcase

    rx_ready_next = is_parse_state(state_next);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command context, timers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_write         <= 1'b0;
      aborted          <= 1'b0;
      addr_hi          <= 8'h00;
      count            <= 9'd0;
      timer            <= 16'd0;
      rx_ready         <= 1'b0;
      tx_data          <= 8'h00;
      tx_valid         <= 1'b0;
      bus_addr         <= '0;
      bus_write_data   <= 8'h00;
      bus_write_enable <= 1'b0;
      bus_read_enable  <= 1'b0;
    end else begin
      is_write         <= is_write_next;
      aborted          <= aborted_next;
      addr_hi          <= addr_hi_next;
      count            <= count_next;
      timer            <= timer_next;
      rx_ready         <= rx_ready_next;
      tx_data          <= tx_data_next;
      tx_valid         <= tx_valid_next;
      bus_addr         <= bus_addr_next;
      bus_write_data   <= bus_write_data_next;
      bus_write_enable <= bus_write_enable_next;
      bus_read_enable  <= bus_read_enable_next;
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
`timescale 1ns/1ps
module tb_debug_bus_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic        bus_ready;
  logic [7:0]  bus_read_data;
  logic        bus_read_valid;

  debug_bus_master #(
    .ADDR_WIDTH   (16),
    .TIMEOUT      (TMO),
    .ACK_BYTE     (8'h4B),
    .TIMEOUT_BYTE (8'hEE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .bus_addr         (bus_addr),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_ready        (bus_ready),
    .bus_read_data    (bus_read_data),
    .bus_read_valid   (bus_read_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Responder memory and per-read response delays (indexed by read number).
  logic [7:0]  mem [0:65535];
  int          delay_tab [0:1023];

  // Observations collected by the monitor.
  logic [23:0] q_wr[$];
  logic [15:0] q_rd[$];
  logic [7:0]  q_tx[$];
  int          q_strobe_cyc[$];
  int          q_txrise_cyc[$];
  int          cyc = 0;
  int          last_rx_cyc = 0;
  int          excl_err = 0;
  int          stab_err = 0;

  bit stall_mode = 1'b0;
  bit noise_mode = 1'b0;
  bit gap_mode   = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor plus responder/sink: samples at negedge, drives at posedge+1.
  initial begin : responder
    int          rv_cnt;
    logic [7:0]  rv_data;
    logic        p_we, p_re, p_br, p_tv, p_tr;
    logic [15:0] p_addr;
    logic [7:0]  p_wd, p_td;
    rv_cnt = 0; rv_data = 8'h00;
    p_we = 1'b0; p_re = 1'b0; p_br = 1'b0; p_tv = 1'b0; p_tr = 1'b0;
    p_addr = 16'h0000; p_wd = 8'h00; p_td = 8'h00;
    bus_ready = 1'b0; tx_ready = 1'b0; bus_read_valid = 1'b0; bus_read_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rv_cnt = 0;
        p_we = 1'b0; p_re = 1'b0; p_tv = 1'b0;
      end else begin
        if (bus_write_enable && bus_read_enable) excl_err++;
        if (rx_ready && (bus_write_enable || bus_read_enable || tx_valid)) excl_err++;
        if ((p_we || p_re) && !p_br &&
            !(bus_write_enable == p_we && bus_read_enable == p_re &&
              bus_addr == p_addr && bus_write_data == p_wd)) stab_err++;
        if ((p_we || p_re) && p_br && (bus_write_enable || bus_read_enable)) stab_err++;
        if (p_tv && !p_tr && !(tx_valid && tx_data == p_td)) stab_err++;
        if (rx_valid && rx_ready) last_rx_cyc = cyc;
        if ((bus_write_enable && !p_we) || (bus_read_enable && !p_re)) q_strobe_cyc.push_back(cyc);
        if (tx_valid && !p_tv) q_txrise_cyc.push_back(cyc);
        if (bus_write_enable && bus_ready) q_wr.push_back({bus_addr, bus_write_data});
        if (bus_read_enable && bus_ready) begin
          rv_cnt  = delay_tab[q_rd.size() % 1024];
          rv_data = mem[bus_addr];
          q_rd.push_back(bus_addr);
        end
        if (tx_valid && tx_ready) q_tx.push_back(tx_data);
        p_we = bus_write_enable; p_re = bus_read_enable; p_br = bus_ready;
        p_addr = bus_addr; p_wd = bus_write_data;
        p_tv = tx_valid; p_tr = tx_ready; p_td = tx_data;
      end
      @(posedge clk); #1;
      bus_read_valid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus_read_valid = 1'b1;
          bus_read_data  = rv_data;
        end
      end else if (noise_mode && $urandom_range(0, 3) == 0) begin
        bus_read_valid = 1'b1;
        bus_read_data  = 8'($urandom);
      end
      bus_ready = stall_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
      tx_ready  = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // Present one byte (called at posedge+1); returns at posedge+1 after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gap_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin @(negedge clk); n++; end
    if (!rx_ready) check_value("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (q_tx.size() < target && n < budget) begin @(negedge clk); n++; end
    if (q_tx.size() < target) check_value("tx_wait_timeout", 32'(q_tx.size()), 32'(target));
    repeat (6) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int wb = q_wr.size();
    int rb = q_rd.size();
    int t0 = q_tx.size();
    @(posedge clk); #1;
    send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(d);
    wait_tx(t0 + 1, 400);
    check_value("wr_count", 32'(q_wr.size() - wb), 32'd1);
    if (q_wr.size() > wb) check_value("wr_addr_data", 32'(q_wr[wb]), {8'h00, a, d});
    check_value("wr_no_read", 32'(q_rd.size() - rb), 32'd0);
    check_value("wr_tx_count", 32'(q_tx.size() - t0), 32'd1);
    if (q_tx.size() > t0) check_value("wr_ack", 32'(q_tx[t0]), 32'h4B);
    check_value("wr_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Reference: N consecutive reads; a delay beyond TMO yields 0xEE and ends the burst.
  task automatic do_read(input logic [15:0] a, input int n, input int dlo, input int dhi, input int abort_at);
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_addr[$];
    int rb = q_rd.size();
    int t0 = q_tx.size();
    int wb = q_wr.size();
    for (int i = 0; i < n; i++) begin
      int d;
      logic [15:0] ai;
      d  = (i == abort_at) ? TMO + 4 : int'($urandom_range(dlo, dhi));
      ai = a + 16'(i);
      delay_tab[(rb + i) % 1024] = d;
      exp_addr.push_back(ai);
      if (d <= TMO) exp_tx.push_back(mem[ai]);
      else begin
        exp_tx.push_back(8'hEE);
        break;
      end
    end
    @(posedge clk); #1;
    send_byte(8'h02); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(n));
    wait_tx(t0 + exp_tx.size(), 100 + 60 * n);
    check_value("rd_count", 32'(q_rd.size() - rb), 32'(exp_addr.size()));
    check_value("rd_tx_count", 32'(q_tx.size() - t0), 32'(exp_tx.size()));
    check_value("rd_no_write", 32'(q_wr.size() - wb), 32'd0);
    foreach (exp_addr[i]) if (rb + i < q_rd.size()) check_value("rd_addr", 32'(q_rd[rb + i]), 32'(exp_addr[i]));
    foreach (exp_tx[i]) if (t0 + i < q_tx.size()) check_value("rd_tx_byte", 32'(q_tx[t0 + i]), 32'(exp_tx[i]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_value({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_value({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check_value({tag, "_wr_en"}, 32'(bus_write_enable), 32'd0);
    check_value({tag, "_rd_en"}, 32'(bus_read_enable), 32'd0);
    check_value({tag, "_addr"}, 32'(bus_addr), 32'd0);
    check_value({tag, "_wdata"}, 32'(bus_write_data), 32'd0);
  endtask

  initial begin : main
    int sb, tr, wb, rb, t0, n;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) delay_tab[i] = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(negedge clk);
    check_value("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Single write
    do_write(16'h0012, 8'h5A);

    // Burst read with latency checks
    mem[16'h0100] = 8'h10; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h12;
    sb = q_strobe_cyc.size(); tr = q_txrise_cyc.size();
    do_read(16'h0100, 3, 1, 1, -1);
    if (q_strobe_cyc.size() > sb + 1) begin
      check_value("lat_strobe", 32'(q_strobe_cyc[sb] - last_rx_cyc), 32'd1);
      check_value("burst_stride", 32'(q_strobe_cyc[sb + 1] - q_strobe_cyc[sb]), 32'd3);
    end else check_value("burst_strobes", 32'(q_strobe_cyc.size() - sb), 32'd3);
    if (q_txrise_cyc.size() > tr) check_value("lat_tx", 32'(q_txrise_cyc[tr] - last_rx_cyc), 32'd3);
    else check_value("burst_tx_rise", 32'(q_txrise_cyc.size() - tr), 32'd3);

    // Stalls on bus and TX
    stall_mode = 1'b1;
    do_write(16'hBEEF, 8'hC3);
    do_read(16'h2000, 5, 1, 3, -1);
    stall_mode = 1'b0;

    // Timeout: silent responder, late valid ignored
    sb = q_strobe_cyc.size(); tr = q_txrise_cyc.size();
    do_read(16'h0040, 3, 14, 14, -1);
    if (q_strobe_cyc.size() > sb && q_txrise_cyc.size() > tr)
      check_value("timeout_latency", 32'(q_txrise_cyc[tr] - q_strobe_cyc[sb]), 32'(TMO + 1));
    else check_value("timeout_events", 32'(q_txrise_cyc.size() - tr), 32'd1);
    repeat (20) @(negedge clk);
    do_read(16'h0050, 1, TMO, TMO, -1);
    do_read(16'h0060, 4, 1, 2, 2);
    repeat (20) @(negedge clk);

    // Wrap with N=0 (256 reads)
    do_read(16'hFFFF, 256, 1, 2, -1);

    // Junk bytes are swallowed without response
    wb = q_wr.size(); rb = q_rd.size(); t0 = q_tx.size();
    @(posedge clk); #1;
    send_byte(8'h7F); send_byte(8'h00);
    repeat (15) @(negedge clk);
    check_value("junk_no_wr", 32'(q_wr.size() - wb), 32'd0);
    check_value("junk_no_rd", 32'(q_rd.size() - rb), 32'd0);
    check_value("junk_no_tx", 32'(q_tx.size() - t0), 32'd0);
    check_value("junk_rx_ready", 32'(rx_ready), 32'd1);
    do_write(16'h0102, 8'h33);

    // Randomized traffic
    noise_mode = 1'b1;
    for (int it = 0; it < 30; it++) begin
      stall_mode = 1'($urandom_range(0, 1));
      gap_mode   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) do_write(16'($urandom), 8'($urandom));
      else do_read(16'($urandom), int'($urandom_range(1, 6)), 1, 10, -1);
      repeat (10) @(negedge clk);
    end
    noise_mode = 1'b0; stall_mode = 1'b0; gap_mode = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of a burst
    for (int i = 0; i < 32; i++) delay_tab[(q_rd.size() + i) % 1024] = 2;
    t0 = q_tx.size();
    @(posedge clk); #1;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    n = 0;
    while (q_tx.size() < t0 + 3 && n < 500) begin @(negedge clk); n++; end
    if (q_tx.size() < t0 + 3) check_value("midburst_progress", 32'(q_tx.size() - t0), 32'd3);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1; reset = 1'b0;
    wb = q_wr.size(); rb = q_rd.size(); t0 = q_tx.size();
    repeat (25) @(negedge clk);
    check_value("post_reset_no_wr", 32'(q_wr.size() - wb), 32'd0);
    check_value("post_reset_no_rd", 32'(q_rd.size() - rb), 32'd0);
    check_value("post_reset_no_tx", 32'(q_tx.size() - t0), 32'd0);
    do_write(16'h4321, 8'h77);

    check_value("exclusive_strobes", 32'(excl_err), 32'd0);
    check_value("hold_stability", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
